// File: rtl/axi_req_tlp_splitter.sv
// Splits one AXI4 AW/AR request into 4DW MemWr/MemRd TLP headers bounded by max payload and 4 KB pages.
// Read mode hands out rolling tags and stalls once all tags are outstanding.
module axi_req_tlp_splitter #(
    parameter int          ADDR_WIDTH        = 64,
    parameter int          ID_WIDTH          = 4,
    parameter int          BEAT_BYTES        = 32,
    parameter int          MAX_PAYLOAD_BYTES = 128,
    parameter bit          IS_READ           = 1'b0,
    parameter int          TAG_WIDTH         = 5,
    parameter logic [15:0] REQUESTER_ID      = 16'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  avalid,
    output logic                  aready,
    input  logic [ADDR_WIDTH-1:0] aaddr,
    input  logic [7:0]            alen,
    input  logic [ID_WIDTH-1:0]   aid,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [127:0]          hdr_data,
    output logic [8:0]            hdr_beats,
    output logic [ID_WIDTH-1:0]   hdr_id,
    output logic                  hdr_last,
    input  logic                  tag_release,
    output logic                  busy
);

    localparam int OFF_BITS = $clog2(BEAT_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BEAT_BYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [16:0]           rem;
    logic [16:0]           seg_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [TAG_WIDTH-1:0]  tag;
    logic [TAG_WIDTH:0]    outstanding;

    logic [63:0]           addr64;
    logic [16:0]           to_boundary;
    logic [16:0]           seg_c;
    logic [9:0]            len_dw;
    logic [3:0]            last_be;
    logic [2:0]            fmt;
    logic [7:0]            tag_field;
    logic                  can_emit;
    logic                  credit_take;
    logic                  credit_give;

    assign addr64 = 64'(addr);
    assign busy   = (state != S_IDLE);

    // Segment size: whatever runs out first of the burst, the payload limit, or the 4 KB page.
    always_comb begin
        to_boundary = 17'd4096 - {5'd0, addr64[11:0]};
        seg_c       = rem;
        if (seg_c > 17'(MAX_PAYLOAD_BYTES)) seg_c = 17'(MAX_PAYLOAD_BYTES);
        if (seg_c > to_boundary)            seg_c = to_boundary;
    end

    assign len_dw    = seg_c[11:2];
    assign last_be   = (seg_c == 17'd4) ? 4'h0 : 4'hF;
    assign fmt       = IS_READ ? 3'b001 : 3'b011;
    assign tag_field = IS_READ ? 8'(tag) : 8'h00;

    // The top outstanding bit is set only when every tag is in flight.
    assign can_emit    = !IS_READ || !outstanding[TAG_WIDTH];
    assign credit_take = IS_READ && (state == S_CALC) && can_emit;
    assign credit_give = IS_READ && tag_release && (outstanding != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            aready    <= 1'b0;
            addr      <= '0;
            rem       <= '0;
            seg_q     <= '0;
            id_q      <= '0;
            tag       <= '0;
            hdr_valid <= 1'b0;
            hdr_data  <= '0;
            hdr_beats <= '0;
            hdr_id    <= '0;
            hdr_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (avalid && aready) begin
                        addr   <= aaddr & ~LOW_MASK;
                        rem    <= (17'(alen) + 17'd1) << OFF_BITS;
                        id_q   <= aid;
                        aready <= 1'b0;
                        state  <= S_CALC;
                    end else begin
                        aready <= 1'b1;
                    end
                end
                S_CALC: begin
                    hdr_data  <= {fmt, 5'b00000, 14'd0, len_dw,
                                  REQUESTER_ID, tag_field, last_be, 4'hF,
                                  addr64[63:32],
                                  addr64[31:0] & 32'hFFFF_FFFC};
                    hdr_beats <= 9'(seg_c >> OFF_BITS);
                    hdr_id    <= id_q;
                    hdr_last  <= (rem == seg_c);
                    seg_q     <= seg_c;
                    if (can_emit) begin
                        hdr_valid <= 1'b1;
                        state     <= S_EMIT;
                        if (IS_READ) tag <= tag + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (hdr_ready) begin
                        hdr_valid <= 1'b0;
                        addr      <= addr + ADDR_WIDTH'(seg_q);
                        rem       <= rem - seg_q;
                        if (hdr_last) begin
                            state  <= S_IDLE;
                            aready <= 1'b1;
                        end else begin
                            state  <= S_CALC;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    aready <= 1'b0;
                end
            endcase
        end
    end

    // A simultaneous take and give leaves the credit count where it was.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else if (credit_take && !credit_give) begin
            outstanding <= outstanding + 1'b1;
        end else if (credit_give && !credit_take) begin
            outstanding <= outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_req_tlp_splitter.sv
// Scoreboard bench: a write-mode and a read-mode splitter, each checked against a queue of
// headers computed from the burst-splitting rules.
module tb_axi_req_tlp_splitter;

    typedef struct {
        logic [127:0] data;
        logic [8:0]   beats;
        logic [3:0]   id;
        logic         last;
    } hdr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         w_avalid = 1'b0, w_aready;
    logic [63:0]  w_aaddr  = '0;
    logic [7:0]   w_alen   = '0;
    logic [3:0]   w_aid    = '0;
    logic         w_hvalid, w_hready = 1'b1, w_hlast, w_busy, w_trel = 1'b0;
    logic [127:0] w_hdata;
    logic [8:0]   w_hbeats;
    logic [3:0]   w_hid;

    logic         r_avalid = 1'b0, r_aready;
    logic [63:0]  r_aaddr  = '0;
    logic [7:0]   r_alen   = '0;
    logic [3:0]   r_aid    = '0;
    logic         r_hvalid, r_hready = 1'b1, r_hlast, r_busy, r_trel = 1'b0;
    logic [127:0] r_hdata;
    logic [8:0]   r_hbeats;
    logic [3:0]   r_hid;

    hdr_t wq[$];
    hdr_t rq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int rd_tag_model = 0;
    int rd_hdr_cnt = 0;
    int rd_rel_cnt = 0;
    bit rel_en = 1'b0;
    bit rel_force = 1'b0;
    int w_ready_mode = 0;
    int r_ready_mode = 0;

    axi_req_tlp_splitter #(
        .ADDR_WIDTH(64), .ID_WIDTH(4), .BEAT_BYTES(32), .MAX_PAYLOAD_BYTES(128),
        .IS_READ(1'b0), .TAG_WIDTH(5), .REQUESTER_ID(16'h0000)
    ) u_wr (
        .clk(clk), .rst(rst), .avalid(w_avalid), .aready(w_aready), .aaddr(w_aaddr),
        .alen(w_alen), .aid(w_aid), .hdr_valid(w_hvalid), .hdr_ready(w_hready),
        .hdr_data(w_hdata), .hdr_beats(w_hbeats), .hdr_id(w_hid), .hdr_last(w_hlast),
        .tag_release(w_trel), .busy(w_busy)
    );

    axi_req_tlp_splitter #(
        .ADDR_WIDTH(64), .ID_WIDTH(4), .BEAT_BYTES(32), .MAX_PAYLOAD_BYTES(128),
        .IS_READ(1'b1), .TAG_WIDTH(2), .REQUESTER_ID(16'hBEEF)
    ) u_rd (
        .clk(clk), .rst(rst), .avalid(r_avalid), .aready(r_aready), .aaddr(r_aaddr),
        .alen(r_alen), .aid(r_aid), .hdr_valid(r_hvalid), .hdr_ready(r_hready),
        .hdr_data(r_hdata), .hdr_beats(r_hbeats), .hdr_id(r_hid), .hdr_last(r_hlast),
        .tag_release(r_trel), .busy(r_busy)
    );

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: got timeout required completion", name);
    endtask

    // Reference split: walk the burst in byte terms, cutting at 128 B and at every 4 KB page.
    task automatic modelBurst(input bit rd, input logic [63:0] a, input logic [7:0] len, input logic [3:0] id);
        logic [63:0] cur;
        int rem, seg, room, ndw;
        hdr_t h;
        cur = a & ~64'd31;
        rem = (int'(len) + 1) * 32;
        while (rem > 0) begin
            room = 4096 - int'(cur & 64'hFFF);
            seg  = rem;
            if (seg > 128)  seg = 128;
            if (seg > room) seg = room;
            ndw = seg / 4;
            h.data[127:96] = {(rd ? 3'b001 : 3'b011), 5'b00000, 14'd0, 10'(ndw % 1024)};
            h.data[95:64]  = {(rd ? 16'hBEEF : 16'h0000), (rd ? 8'(rd_tag_model % 4) : 8'h00),
                              ((ndw == 1) ? 4'h0 : 4'hF), 4'hF};
            h.data[63:32]  = cur[63:32];
            h.data[31:0]   = {cur[31:2], 2'b00};
            h.beats = 9'(seg / 32);
            h.id    = id;
            h.last  = (rem == seg);
            if (rd) begin
                rq.push_back(h);
                rd_tag_model++;
            end else begin
                wq.push_back(h);
            end
            cur = cur + 64'(seg);
            rem = rem - seg;
        end
    endtask

    task automatic applyStimulus(input bit rd, input logic [63:0] a, input logic [7:0] len, input logic [3:0] id);
        bit ok;
        ok = 1'b0;
        modelBurst(rd, a, len, id);
        @(posedge clk); #1;
        if (rd) begin
            r_avalid = 1'b1; r_aaddr = a; r_alen = len; r_aid = id;
        end else begin
            w_avalid = 1'b1; w_aaddr = a; w_alen = len; w_aid = id;
        end
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if ((rd ? r_aready : w_aready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) reportFail("accept_timeout");
        @(posedge clk); #1;
        if (rd) r_avalid = 1'b0;
        else    w_avalid = 1'b0;
    endtask

    task automatic waitDrain(input bit rd, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((rd ? rq.size() : wq.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) reportFail(rd ? "rd_drain_timeout" : "wr_drain_timeout");
    endtask

    task automatic checkHeader(input bit rd);
        hdr_t h;
        logic [127:0] d;
        logic [8:0] b;
        logic [3:0] id;
        logic l, rdy, ar;
        d   = rd ? r_hdata  : w_hdata;
        b   = rd ? r_hbeats : w_hbeats;
        id  = rd ? r_hid    : w_hid;
        l   = rd ? r_hlast  : w_hlast;
        rdy = rd ? r_hready : w_hready;
        ar  = rd ? r_aready : w_aready;
        if ((rd ? rq.size() : wq.size()) == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s: got header %h required no header", rd ? "rd_unexpected" : "wr_unexpected", d);
        end else begin
            h = rd ? rq[0] : wq[0];
            checkOutput(rd ? "rd_hdr_data"  : "wr_hdr_data",  d, h.data);
            checkOutput(rd ? "rd_hdr_beats" : "wr_hdr_beats", 128'(b), 128'(h.beats));
            checkOutput(rd ? "rd_hdr_id"    : "wr_hdr_id",    128'(id), 128'(h.id));
            checkOutput(rd ? "rd_hdr_last"  : "wr_hdr_last",  128'(l), 128'(h.last));
            checkOutput(rd ? "rd_aready_busy" : "wr_aready_busy", 128'(ar), 128'(0));
            if (rdy) begin
                if (rd) begin
                    void'(rq.pop_front());
                    rd_hdr_cnt++;
                end else begin
                    void'(wq.pop_front());
                end
            end
        end
    endtask

    // Monitors: compare whatever the DUT presents against the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (w_hvalid !== 1'b0) checkHeader(1'b0);
            if (r_hvalid !== 1'b0) checkHeader(1'b1);
        end
    end

    // Consumer-ready and completion-release drivers.
    initial begin
        forever begin
            @(posedge clk); #1;
            w_hready = (w_ready_mode == 0) ? 1'b1 : (w_ready_mode == 1) ? ($urandom % 3 != 0) : 1'b0;
            r_hready = (r_ready_mode == 0) ? 1'b1 : ($urandom % 3 != 0);
            if (rel_force || (rel_en && (rd_hdr_cnt - rd_rel_cnt) > 0 && ($urandom % 3 == 0))) begin
                r_trel = 1'b1;
                rd_rel_cnt++;
                rel_force = 1'b0;
            end else begin
                r_trel = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkResetOutputs(input string tagname);
        checkOutput({tagname, "_w_aready"}, 128'(w_aready), 128'(0));
        checkOutput({tagname, "_w_hvalid"}, 128'(w_hvalid), 128'(0));
        checkOutput({tagname, "_w_hdata"},  w_hdata, 128'(0));
        checkOutput({tagname, "_w_hbeats"}, 128'(w_hbeats), 128'(0));
        checkOutput({tagname, "_w_hid"},    128'(w_hid), 128'(0));
        checkOutput({tagname, "_w_hlast"},  128'(w_hlast), 128'(0));
        checkOutput({tagname, "_w_busy"},   128'(w_busy), 128'(0));
        checkOutput({tagname, "_r_aready"}, 128'(r_aready), 128'(0));
        checkOutput({tagname, "_r_hvalid"}, 128'(r_hvalid), 128'(0));
        checkOutput({tagname, "_r_busy"},   128'(r_busy), 128'(0));
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        checkOutput("aready_at_release", 128'(w_aready), 128'(0));
        @(negedge clk);
        checkOutput("aready_after_release", 128'(w_aready), 128'(1));

        // Single beat write: CALC bubble, then the header two cycles after accept.
        applyStimulus(1'b0, 64'h1000, 8'd0, 4'h3);
        @(negedge clk);
        checkOutput("latency_calc", 128'(w_hvalid), 128'(0));
        @(negedge clk);
        checkOutput("latency_emit", 128'(w_hvalid), 128'(1));
        checkOutput("s1_hdr_const", w_hdata, 128'h60000008_000000FF_00000000_00001000);
        waitDrain(1'b0, 50);

        applyStimulus(1'b0, 64'h0, 8'd15, 4'h1);
        applyStimulus(1'b0, 64'hFC0, 8'd3, 4'h2);
        applyStimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFE0, 8'd3, 4'h4);
        applyStimulus(1'b0, 64'h1017, 8'd1, 4'h6);
        waitDrain(1'b0, 500);

        // Consumer stall: header must stay put while hdr_ready is low.
        w_ready_mode = 2;
        applyStimulus(1'b0, 64'h2000, 8'd7, 4'h5);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (w_hvalid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) reportFail("stall_hvalid_timeout");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_hvalid", 128'(w_hvalid), 128'(1));
        end
        w_ready_mode = 0;
        waitDrain(1'b0, 200);

        w_ready_mode = 1;
        for (int n = 0; n < 25; n++) begin
            applyStimulus(1'b0, {$urandom, $urandom},
                          ($urandom % 8 == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 31)),
                          4'($urandom));
        end
        waitDrain(1'b0, 20000);
        w_ready_mode = 0;

        // Tag exhaustion: four tags go out, the fifth waits for a release and reuses tag 0.
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, 64'(n) * 64'h100, 8'd0, 4'(n));
        end
        repeat (30) @(negedge clk);
        checkOutput("tag_stall_pending", 128'(rq.size()), 128'(1));
        checkOutput("tag_stall_hvalid", 128'(r_hvalid), 128'(0));
        checkOutput("tag_stall_busy", 128'(r_busy), 128'(1));
        rel_force = 1'b1;
        waitDrain(1'b1, 100);

        rel_en = 1'b1;
        r_ready_mode = 1;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(1'b1, {$urandom, $urandom}, 8'($urandom_range(0, 15)), 4'($urandom));
        end
        waitDrain(1'b1, 20000);
        rel_en = 1'b0;
        r_ready_mode = 0;

        // Reset in the middle of the second segment of a four-header burst.
        w_ready_mode = 0;
        applyStimulus(1'b0, 64'h0, 8'd15, 4'h2);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wq.size() == 3) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) reportFail("midburst_first_hdr_timeout");
        @(negedge clk);
        rst = 1'b1;
        wq.delete();
        rq.delete();
        #2;
        checkResetOutputs("midburst_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("post_reset_hvalid", 128'(w_hvalid), 128'(0));
        checkOutput("post_reset_busy", 128'(w_busy), 128'(0));
        checkOutput("post_reset_aready", 128'(w_aready), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
